// File: rtl/apb_rr_sequencer.sv
// Round-robin arbiter that shares one APB master port among NREQ requesters.
// One transfer at a time (SETUP/ACCESS), with a pready timeout. Every output is registered.
module apb_rr_sequencer #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 pclk,
    input  logic                 prst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [AW-1:0]        paddr,
    output logic [DW-1:0]        pwdata,
    input  logic [DW-1:0]        prdata,
    input  logic                 pready,
    input  logic                 pslverr
);

    localparam int PW = $clog2(NREQ);

    // GRANT is the cycle in which the registered req_ready pulse is visible.
    // The response cycle is the first IDLE cycle after ACCESS, and it already arbitrates.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] SETUP  = 2'd2;
    localparam logic [1:0] ACCESS = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            pwrite_q, pwrite_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];
    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*AW +: AW];
        assign wdata_arr[i] = req_wdata[i*DW +: DW];
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        found       = 1'b0;
        pick        = '0;
        cand        = '0;

        // First valid requester at or after the rotating pointer.
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_d[pick] = 1'b1;
                    grant_d           = pick;
                    ptr_d             = (int'(pick) == NREQ - 1) ? '0 : pick + PW'(1);
                    pwrite_d          = req_write[pick];
                    paddr_d           = addr_arr[pick];
                    pwdata_d          = wdata_arr[pick];
                    state_d           = GRANT;
                end
            end
            GRANT: begin
                psel_d  = 1'b1;
                state_d = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            default: begin
                // A pready on the last permitted wait cycle still completes normally.
                if (pready || cnt_q == 8'(TIMEOUT - 1)) begin
                    psel_d               = 1'b0;
                    penable_d            = 1'b0;
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_err_d            = pslverr | ~pready;
                    rsp_rdata_d          = (pready && !pslverr && !pwrite_q) ? prdata : '0;
                    cnt_d                = '0;
                    state_d              = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_rr_sequencer.sv
// Randomized scoreboard bench for apb_rr_sequencer: a transfer-level model predicts grants,
// bus phases and responses; a separate monitor pops expected responses when the DUT answers.
module tb_apb_rr_sequencer;

    localparam int NREQ    = 3;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 16;

    localparam int PH_IDLE   = 0;
    localparam int PH_GRANT  = 1;
    localparam int PH_SETUP  = 2;
    localparam int PH_ACCESS = 3;
    localparam int PH_RESP   = 4;

    logic                 pclk = 1'b0;
    logic                 prst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_write = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [AW-1:0]        paddr;
    logic [DW-1:0]        pwdata;
    logic [DW-1:0]        prdata = '0;
    logic                 pready = 1'b0;
    logic                 pslverr = 1'b0;

    always #5 pclk = ~pclk;

    apb_rr_sequencer #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .prst_n(prst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    typedef struct {
        int          id;
        logic [DW-1:0] rdata;
        logic        err;
        longint      due;
    } rsp_t;

    rsp_t   exp_q[$];
    rsp_t   mon_e;
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    logic          pend_valid [NREQ];
    logic          pend_write [NREQ];
    logic [AW-1:0] pend_addr  [NREQ];
    logic [DW-1:0] pend_wdata [NREQ];

    int            ptr = 0, exp_g = 0, nxt_phase = PH_IDLE, cur = PH_IDLE, last_cur = PH_IDLE;
    int            acc_cnt = 0, act_id = 0, plan_waits = 0, ghost_id = -1;
    logic          act_write = 1'b0, plan_err = 1'b0;
    logic [AW-1:0] act_addr = '0;
    logic [DW-1:0] act_wdata = '0, plan_data = '0, force_data = '0;
    int            gen_mask = 0, gen_pct = 0, gen_write = -1, force_waits = -1, force_err = -1;
    bit            force_data_en = 1'b0, ghost_en = 1'b0, rst_recheck = 1'b0, reached = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic postRequest(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend_valid[i] = 1'b1;
        pend_write[i] = w;
        pend_addr[i]  = a;
        pend_wdata[i] = d;
        req_valid[i]  = 1'b1;
        req_write[i]  = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    function automatic int pickNext();
        for (int k = 0; k < NREQ; k++)
            if (pend_valid[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // An idle DUT samples the requests driven during this cycle at the next edge.
    task automatic modelSample();
        if (last_cur == PH_IDLE || last_cur == PH_RESP) begin
            exp_g = pickNext();
            nxt_phase = (exp_g >= 0) ? PH_GRANT : PH_IDLE;
        end
    endtask

    task automatic planTransfer();
        int r;
        r = int'($urandom % 20);
        if (force_waits >= 0)   plan_waits = force_waits;
        else if (r == 0)        plan_waits = 1000;
        else if (r == 1)        plan_waits = TIMEOUT - 1;
        else if (r < 10)        plan_waits = 0;
        else                    plan_waits = int'($urandom % 5);
        plan_err  = (force_err >= 0) ? force_err[0] : ($urandom % 8 == 0);
        plan_data = force_data_en ? force_data : DW'($urandom);
    endtask

    task automatic applyStimulus(input int ncycles, input bit stop_at_access);
        reached = 1'b0;
        for (int n = 0; n < ncycles; n++) begin
            @(negedge pclk);
            cur = nxt_phase;
            if (stop_at_access && cur == PH_ACCESS) begin
                reached = 1'b1;
                return;
            end
            last_cur = cur;
            if (ghost_id >= 0) begin
                req_valid[ghost_id] = 1'b0;
                ghost_id = -1;
            end
            checkOutput("req_ready", 64'(req_ready), (cur == PH_GRANT) ? (64'd1 << exp_g) : 64'd0);
            checkOutput("apb_phase", 64'({psel, penable}),
                        (cur == PH_SETUP) ? 64'd2 : (cur == PH_ACCESS) ? 64'd3 : 64'd0);
            if (cur == PH_SETUP || cur == PH_ACCESS) begin
                checkOutput("paddr", 64'(paddr), 64'(act_addr));
                checkOutput("pwrite", 64'(pwrite), 64'(act_write));
                checkOutput("pwdata", 64'(pwdata), 64'(act_wdata));
            end
            pready  = $urandom % 2 == 0;
            pslverr = $urandom % 2 == 0;
            prdata  = DW'($urandom);
            case (cur)
                PH_GRANT: begin
                    if (rst_recheck) begin
                        checkOutput("reset_first_grant", 64'(req_ready), 64'd1);
                        rst_recheck = 1'b0;
                    end
                    act_id = exp_g;
                    act_write = pend_write[exp_g];
                    act_addr = pend_addr[exp_g];
                    act_wdata = pend_wdata[exp_g];
                    pend_valid[exp_g] = 1'b0;
                    req_valid[exp_g] = 1'b0;
                    ptr = (exp_g + 1) % NREQ;
                    planTransfer();
                    nxt_phase = PH_SETUP;
                end
                PH_SETUP: begin
                    acc_cnt = 0;
                    nxt_phase = PH_ACCESS;
                end
                PH_ACCESS: begin
                    acc_cnt++;
                    if (acc_cnt > plan_waits) begin
                        pready = 1'b1;
                        prdata = plan_data;
                        pslverr = plan_err;
                        exp_q.push_back('{act_id, (act_write || plan_err) ? '0 : plan_data, plan_err, cyc + 1});
                        nxt_phase = PH_RESP;
                    end else begin
                        pready = 1'b0;
                        if (acc_cnt == TIMEOUT) begin
                            exp_q.push_back('{act_id, '0, 1'b1, cyc + 1});
                            nxt_phase = PH_RESP;
                        end
                    end
                end
                default: nxt_phase = PH_IDLE;
            endcase
            for (int i = 0; i < NREQ; i++) begin
                if (!pend_valid[i]) begin
                    req_write[i] = $urandom % 2 == 0;
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_wdata[i*DW +: DW] = DW'($urandom);
                    if (gen_mask[i] && int'($urandom % 100) < gen_pct)
                        postRequest(i, (gen_write < 0) ? ($urandom % 2 == 0) : gen_write[0],
                                    AW'($urandom) & ~AW'(3), DW'($urandom));
                end
            end
            // A short-lived request while busy must be ignored and never answered.
            if (ghost_en && ($urandom % 4 == 0) &&
                (cur == PH_GRANT || cur == PH_SETUP || (cur == PH_ACCESS && nxt_phase == PH_ACCESS))) begin
                for (int i = 0; i < NREQ; i++)
                    if (ghost_id < 0 && !pend_valid[i]) ghost_id = i;
                if (ghost_id >= 0) req_valid[ghost_id] = 1'b1;
            end
            modelSample();
        end
    endtask

    always @(negedge pclk) begin
        if (prst_n) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                mon_e = exp_q.pop_front();
                checkOutput("rsp_valid", 64'(rsp_valid), 64'd1 << mon_e.id);
                checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(mon_e.rdata));
                checkOutput("rsp_err", 64'(rsp_err), 64'(mon_e.err));
            end else if (rsp_valid != '0) begin
                checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int npend;
        for (int i = 0; i < NREQ; i++) pend_valid[i] = 1'b0;
        repeat (3) @(negedge pclk);
        checkOutput("reset_req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("reset_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("reset_psel", 64'({psel, penable, pwrite}), 64'd0);
        checkOutput("reset_paddr", 64'(paddr), 64'd0);
        checkOutput("reset_pwdata", 64'(pwdata), 64'd0);
        prst_n = 1'b1;

        $display("[TB] single read");
        force_waits = 0; force_err = 0; force_data_en = 1'b1; force_data = 32'hA5;
        postRequest(0, 1'b0, 32'h0C, 32'h0);
        modelSample();
        applyStimulus(8, 1'b0);

        $display("[TB] alternating writes");
        force_data_en = 1'b0;
        gen_mask = 3; gen_pct = 100; gen_write = 1;
        postRequest(0, 1'b1, 32'h100, 32'h1111);
        postRequest(1, 1'b1, 32'h200, 32'h2222);
        modelSample();
        applyStimulus(34, 1'b0);
        gen_pct = 0;
        applyStimulus(30, 1'b0);

        $display("[TB] wait states");
        force_waits = 3;
        postRequest(1, 1'b1, 32'h2C, 32'h5A);
        modelSample();
        applyStimulus(12, 1'b0);

        $display("[TB] timeout");
        force_waits = 1000;
        postRequest(0, 1'b0, 32'h40, 32'h0);
        modelSample();
        applyStimulus(24, 1'b0);

        $display("[TB] slave error and last-cycle pready");
        force_waits = 0; force_err = 1;
        postRequest(2, 1'b0, 32'h44, 32'h0);
        modelSample();
        applyStimulus(8, 1'b0);
        force_waits = TIMEOUT - 1; force_err = 0;
        postRequest(1, 1'b0, 32'h48, 32'h0);
        modelSample();
        applyStimulus(24, 1'b0);

        $display("[TB] random traffic");
        force_waits = -1; force_err = -1;
        gen_mask = 7; gen_pct = 30; gen_write = -1; ghost_en = 1'b1;
        applyStimulus(3000, 1'b0);

        $display("[TB] reset during access");
        gen_pct = 0; ghost_en = 1'b0; force_waits = 1000;
        applyStimulus(80, 1'b0);
        postRequest(0, 1'b0, 32'h80, 32'h0);
        modelSample();
        applyStimulus(40, 1'b1);
        checkOutput("reset_reach_access", 64'(reached), 64'd1);
        prst_n = 1'b0;
        #1;
        checkOutput("reset_async_psel", 64'({psel, penable}), 64'd0);
        exp_q.delete();
        ghost_id = -1;
        for (int i = 0; i < NREQ; i++) begin
            pend_valid[i] = 1'b0;
            req_valid[i] = 1'b0;
        end
        @(negedge pclk);
        checkOutput("reset_hold_outputs", 64'({req_ready, rsp_valid, psel, penable}), 64'd0);
        force_waits = -1;
        postRequest(1, 1'b1, 32'h90, 32'h99);
        postRequest(0, 1'b1, 32'h94, 32'h98);
        ptr = 0; last_cur = PH_IDLE; rst_recheck = 1'b1;
        prst_n = 1'b1;
        modelSample();
        gen_pct = 30; ghost_en = 1'b1;
        applyStimulus(300, 1'b0);

        gen_pct = 0; ghost_en = 1'b0;
        applyStimulus(200, 1'b0);
        npend = 0;
        for (int i = 0; i < NREQ; i++) if (pend_valid[i]) npend++;
        checkOutput("drain_pending", 64'(npend), 64'd0);
        checkOutput("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
